// File: rtl/br_resolve.sv
// br_resolve: EX-stage conditional branch resolution with a held redirect toward IF.
// Define BR_STAT_EN to add saturating branch/taken statistics counters (stat_br_cnt, stat_taken_cnt).

module cmp #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_arg0,
    input  logic [WIDTH-1:0] i_arg1,
    output logic             o_true
);

    localparam logic [2:0] CMP_OP_EQ  = 3'd0;
    localparam logic [2:0] CMP_OP_NE  = 3'd1;
    localparam logic [2:0] CMP_OP_LT  = 3'd4;
    localparam logic [2:0] CMP_OP_GE  = 3'd5;
    localparam logic [2:0] CMP_OP_LTU = 3'd6;
    localparam logic [2:0] CMP_OP_GEU = 3'd7;

    // Opcodes 2 and 3 are unassigned and must never report a true condition.
    always_comb begin
        o_true = 1'b0;
        case (i_op)
            CMP_OP_EQ:  o_true = (i_arg0 == i_arg1);
            CMP_OP_NE:  o_true = (i_arg0 != i_arg1);
            CMP_OP_LT:  o_true = ($signed(i_arg0) <  $signed(i_arg1));
            CMP_OP_GE:  o_true = ($signed(i_arg0) >= $signed(i_arg1));
            CMP_OP_LTU: o_true = (i_arg0 <  i_arg1);
            CMP_OP_GEU: o_true = (i_arg0 >= i_arg1);
            default:    o_true = 1'b0;
        endcase
    end

endmodule

module br_resolve #(
    parameter int WIDTH = 32
`ifdef BR_STAT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_en,
    input  logic             ex_is_br,
    input  logic [2:0]       ex_br_op,
    input  logic [WIDTH-1:0] ex_rs1,
    input  logic [WIDTH-1:0] ex_rs2,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [WIDTH-1:0] ex_br_offset,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_ack,
    output logic             redirect_req,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             br_taken,
    output logic             br_misalign,
`ifdef BR_STAT_EN
    output logic [CNT_W-1:0] stat_br_cnt,
    output logic [CNT_W-1:0] stat_taken_cnt,
`endif
    output logic             busy
);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_cond;
    logic             w_accept;
    logic             w_aligned;
    logic [WIDTH-1:0] w_tgt;
    logic [WIDTH-1:0] r_redirect_pc;
    logic             r_br_taken;
    logic             r_br_misalign;

    cmp #(.WIDTH(WIDTH)) u_cmp (
        .i_op   (ex_br_op),
        .i_arg0 (ex_rs1),
        .i_arg1 (ex_rs2),
        .o_true (w_cond)
    );

    assign w_tgt     = ex_pc + ex_br_offset;
    assign w_aligned = (w_tgt[1:0] == 2'b00);
    assign w_accept  = ex_en & ex_is_br & ~stall & ~flush & (r_state == IDLE);

    // Flush and ack both retire the pending redirect; they lead to the same result.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (w_accept & w_cond & w_aligned) w_next_state = WAIT_ACK;
            WAIT_ACK: if (flush | redirect_ack) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_redirect_pc <= '0;
            r_br_taken    <= 1'b0;
            r_br_misalign <= 1'b0;
        end else begin
            r_br_taken    <= w_accept & w_cond;
            r_br_misalign <= w_accept & w_cond & ~w_aligned;
            if (w_accept & w_cond & w_aligned) begin
                r_redirect_pc <= w_tgt;
            end
        end
    end

    assign redirect_req = (r_state == WAIT_ACK);
    assign busy         = (r_state == WAIT_ACK);
    assign redirect_pc  = r_redirect_pc;
    assign br_taken     = r_br_taken;
    assign br_misalign  = r_br_misalign;

`ifdef BR_STAT_EN
    logic [CNT_W-1:0] r_stat_br_cnt;
    logic [CNT_W-1:0] r_stat_taken_cnt;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_br_cnt    <= '0;
            r_stat_taken_cnt <= '0;
        end else begin
            if (w_accept && (r_stat_br_cnt != '1)) begin
                r_stat_br_cnt <= r_stat_br_cnt + CNT_W'(1);
            end
            if (w_accept && w_cond && (r_stat_taken_cnt != '1)) begin
                r_stat_taken_cnt <= r_stat_taken_cnt + CNT_W'(1);
            end
        end
    end

    assign stat_br_cnt    = r_stat_br_cnt;
    assign stat_taken_cnt = r_stat_taken_cnt;
`endif

endmodule
